// File: rtl/control_fsm.sv
// Multi-cycle processor control unit: a Moore FSM that sequences fetch,
// decode, execute, memory and write-back steps and drives the datapath
// select/enable lines. All outputs are registered copies of decodes of the
// next state, so they always describe the state currently held in state_q.
module control_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        halt,
    output logic        SelectIns,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        BEQ,
    output logic [1:0]  PCSrc,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WB_R     = 4'd4,
        EXEC_I   = 4'd5,
        WB_I     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        WB_MEM   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12
    } state_e;

    typedef struct packed {
        logic       sel_ins;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_write;
        logic       memto_reg;
        logic       beq;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       ir_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e      state_q;
    state_e      state_d;
    logic [5:0]  opcode_q;
    ctrl_t       ctrl_q;
    logic        instr_done_q;
    logic        illegal_q;
    logic [15:0] retired_q;

    // Terminal states last exactly one cycle and retire the instruction.
    function automatic logic is_terminal(input state_e s);
        return (s == WB_R) || (s == WB_I) || (s == WB_MEM) ||
               (s == MEM_WR) || (s == BRANCH) || (s == JUMP);
    endfunction

    function automatic logic is_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
    endfunction

    // Datapath control word for each state; unlisted fields stay 0.
    function automatic ctrl_t decode_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: begin
                c.alu_src_b = 2'b10;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            WB_I: begin
                c.reg_write = 1'b1;
            end
            MEM_RD: begin
                c.sel_ins = 1'b1;
            end
            WB_MEM: begin
                c.reg_write = 1'b1;
                c.memto_reg = 1'b1;
            end
            MEM_WR: begin
                c.sel_ins   = 1'b1;
                c.mem_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.beq       = 1'b1;
                c.pc_src    = 2'b01;
            end
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state selection; halt is only consulted at instruction boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = halt ? IDLE : FETCH;
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_ADDI:      state_d = EXEC_I;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            EXEC_R:   state_d = WB_R;
            EXEC_I:   state_d = WB_I;
            // Only LW and SW reach MEM_ADDR, so the latched opcode picks one.
            MEM_ADDR: state_d = (opcode_q == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = WB_MEM;
            WB_R, WB_I, WB_MEM, MEM_WR, BRANCH, JUMP:
                      state_d = halt ? IDLE : FETCH;
            default:  state_d = IDLE;
        endcase
    end

    // State, latched opcode, registered control word, status pulses and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            opcode_q     <= '0;
            ctrl_q       <= '0;
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= decode_ctrl(state_d);
            instr_done_q <= is_terminal(state_d);
            illegal_q    <= (state_q == DECODE) && !is_known(opcode);
            if (state_q == DECODE) begin
                opcode_q <= opcode;
            end
            if (is_terminal(state_q)) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    assign SelectIns  = ctrl_q.sel_ins;
    assign RegWrite   = ctrl_q.reg_write;
    assign RegDst     = ctrl_q.reg_dst;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign MemWrite   = ctrl_q.mem_write;
    assign MemtoReg   = ctrl_q.memto_reg;
    assign BEQ        = ctrl_q.beq;
    assign PCSrc      = ctrl_q.pc_src;
    assign PCWrite    = ctrl_q.pc_write;
    assign IRWrite    = ctrl_q.ir_write;
    assign alu_op     = ctrl_q.alu_op;
    assign state      = state_q;
    assign instr_done = instr_done_q;
    assign illegal    = illegal_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-cycle expectations (state, control word,
// pulses, retire count) are queued when an instruction is issued and
// compared on the falling edge while the DUT walks through its states.
module tb_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_WB_R = 4;
  localparam int S_EXEC_I = 5, S_WB_I = 6, S_MEM_ADDR = 7, S_MEM_RD = 8;
  localparam int S_WB_MEM = 9, S_MEM_WR = 10, S_BRANCH = 11, S_JUMP = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic halt = 1'b0;

  always #5 clk = ~clk;

  logic        SelectIns, RegWrite, RegDst, ALUSrcA, MemWrite, MemtoReg, BEQ;
  logic        PCWrite, IRWrite, instr_done, illegal;
  logic [1:0]  ALUSrcB, PCSrc, alu_op;
  logic [3:0]  state;
  logic [15:0] retired;

  control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .halt       (halt),
    .SelectIns  (SelectIns),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .BEQ        (BEQ),
    .PCSrc      (PCSrc),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .alu_op     (alu_op),
    .state      (state),
    .instr_done (instr_done),
    .illegal    (illegal),
    .retired    (retired)
  );

  logic [14:0] obs_ctrl;
  assign obs_ctrl = {SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite,
                     MemtoReg, BEQ, PCSrc, PCWrite, IRWrite, alu_op};

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word per state, straight from the output table.
  function automatic logic [14:0] ctrl_of(input int s);
    logic sel, rw, rd, asa, mw, m2r, beq, pcw, irw;
    logic [1:0] asb, pcs, aop;
    {sel, rw, rd, asa, mw, m2r, beq, pcw, irw} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (s)
      S_FETCH:    begin irw = 1; pcw = 1; asb = 2'b01; end
      S_DECODE:   begin asb = 2'b10; end
      S_EXEC_R:   begin asa = 1; asb = 2'b00; aop = 2'b10; end
      S_WB_R:     begin rw = 1; rd = 1; end
      S_EXEC_I:   begin asa = 1; asb = 2'b10; end
      S_WB_I:     begin rw = 1; end
      S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin sel = 1; end
      S_WB_MEM:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin sel = 1; mw = 1; end
      S_BRANCH:   begin asa = 1; aop = 2'b01; beq = 1; pcs = 2'b01; end
      S_JUMP:     begin pcw = 1; pcs = 2'b10; end
      default:    ;
    endcase
    return {sel, rw, rd, asa, asb, mw, m2r, beq, pcs, pcw, irw, aop};
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    return op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_J;
  endfunction

  // ---------------- scoreboard ----------------
  // record: [36:33] state, [32:18] ctrl, [17] instr_done, [16] illegal, [15:0] retired
  logic [36:0] exp_q[$];
  logic [15:0] model_retired = '0;
  bit pending_illegal = 0;

  task automatic push_exp(input int s);
    bit term;
    term = (s == S_WB_R || s == S_WB_I || s == S_WB_MEM || s == S_MEM_WR ||
            s == S_BRANCH || s == S_JUMP);
    exp_q.push_back({4'(s), ctrl_of(s), term, pending_illegal, model_retired});
    pending_illegal = 0;
    if (term) model_retired = model_retired + 16'd1;
  endtask

  always @(negedge clk) begin
    logic [36:0] rec;
    if (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      check_eq("state", {12'd0, state}, {12'd0, rec[36:33]});
      check_eq("ctrl", {1'b0, obs_ctrl}, {1'b0, rec[32:18]});
      check_eq("pulses", {14'd0, instr_done, illegal}, {14'd0, rec[17:16]});
      check_eq("retired", retired, rec[15:0]);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+2 of a FETCH cycle; walks the queue dry with a cycle budget.
  task automatic wait_drain(input int halt_at);
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #2;
      // Past the DECODE edge the opcode must no longer matter.
      if (k == 1) opcode = 6'($urandom_range(0, 63));
      if (k == halt_at) halt = 1'b1;
    end
    check_eq("drain", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
  endtask

  task automatic exec_instr(input logic [5:0] op, input int halt_at, input int n_idle);
    opcode = op;
    push_exp(S_FETCH);
    push_exp(S_DECODE);
    case (op)
      OP_R:    begin push_exp(S_EXEC_R); push_exp(S_WB_R); end
      OP_ADDI: begin push_exp(S_EXEC_I); push_exp(S_WB_I); end
      OP_LW:   begin push_exp(S_MEM_ADDR); push_exp(S_MEM_RD); push_exp(S_WB_MEM); end
      OP_SW:   begin push_exp(S_MEM_ADDR); push_exp(S_MEM_WR); end
      OP_BEQ:  push_exp(S_BRANCH);
      OP_J:    push_exp(S_JUMP);
      default: pending_illegal = 1;
    endcase
    for (int i = 0; i < n_idle; i++) push_exp(S_IDLE);
    wait_drain(halt_at);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] ops [6];
    logic [5:0] rop;
    ops[0] = OP_R; ops[1] = OP_ADDI; ops[2] = OP_LW;
    ops[3] = OP_SW; ops[4] = OP_BEQ; ops[5] = OP_J;

    // Reset state, held without any clock edge dependency.
    #2;
    check_eq("rst_state", {12'd0, state}, 16'd0);
    check_eq("rst_ctrl", {1'b0, obs_ctrl}, 16'd0);
    check_eq("rst_pulses", {14'd0, instr_done, illegal}, 16'd0);
    check_eq("rst_retired", retired, 16'd0);

    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check_eq("leave_idle", {12'd0, state}, 16'(S_FETCH));

    // Directed paths.
    exec_instr(OP_R, -1, 0);
    exec_instr(OP_LW, -1, 0);
    exec_instr(OP_SW, -1, 0);
    exec_instr(OP_BEQ, -1, 0);
    exec_instr(OP_J, -1, 0);
    exec_instr(6'b111111, -1, 0);
    exec_instr(OP_R, -1, 0);

    // Random mix including unrecognised opcodes.
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rop = 6'($urandom_range(0, 63));
        while (known_op(rop)) rop = 6'($urandom_range(0, 63));
      end else begin
        rop = ops[$urandom_range(0, 5)];
      end
      exec_instr(rop, -1, 0);
    end

    // halt raised during EXEC_I: WB_I still completes, then IDLE holds.
    exec_instr(OP_ADDI, 1, 3);
    check_eq("halt_hold", {12'd0, state}, 16'(S_IDLE));
    halt = 1'b0;
    @(posedge clk); #2;
    check_eq("halt_release", {12'd0, state}, 16'(S_FETCH));

    // Reset in the middle of MEM_WR.
    opcode = OP_SW;
    push_exp(S_FETCH);
    push_exp(S_DECODE);
    push_exp(S_MEM_ADDR);
    wait_drain(-1);
    check_eq("sw_state", {12'd0, state}, 16'(S_MEM_WR));
    check_eq("sw_memwrite", {15'd0, MemWrite}, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_memwrite", {15'd0, MemWrite}, 16'd0);
    check_eq("rst_regwrite", {15'd0, RegWrite}, 16'd0);
    check_eq("rst_pcwrite", {15'd0, PCWrite}, 16'd0);
    check_eq("rst_mid_state", {12'd0, state}, 16'd0);
    check_eq("rst_mid_retired", retired, 16'd0);
    model_retired = '0;
    pending_illegal = 0;

    // Wrap of the retire counter from a preloaded 0xFFFF.
    halt = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check_eq("halt_after_rst", {12'd0, state}, 16'(S_IDLE));
    dut.retired_q = 16'hFFFF;
    model_retired = 16'hFFFF;
    halt = 1'b0;
    @(posedge clk); #2;
    exec_instr(OP_J, -1, 0);
    exec_instr(OP_BEQ, -1, 0);
    check_eq("wrap_retired", retired, model_retired);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
